// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: requester count,
// select width, FSM state encoding and the index-to-one-hot helper.
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo 4.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = ptr;
        cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 select path among 4 valid/ready
// requesters, with a per-grant burst cap and rotation on valid drop.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [SEL_W-1:0]            sel,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] pick_ptr;
    logic             beat;
    logic             release_now;
    logic [DATA_W-1:0] data_mux;

    // In GRANT the picker is only consulted on a release, so it can always
    // look from the slot after the current owner.
    assign pick_ptr = (state == ST_GRANT) ? sel + 2'd1 : ptr;

    rr_pick4 u_pick (
        .req (req_valid),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign out_valid   = (|gnt) & req_valid[sel];
    assign beat        = out_valid & out_ready;
    assign release_now = (beat && (beat_cnt == LAST_BEAT)) || !req_valid[sel];
    assign req_ready   = gnt & {NUM_REQ{out_ready}};

    always_comb begin
        data_mux = '0;
        case (sel)
            2'b00:   data_mux = req_data[0*DATA_W +: DATA_W];
            2'b01:   data_mux = req_data[1*DATA_W +: DATA_W];
            2'b10:   data_mux = req_data[2*DATA_W +: DATA_W];
            2'b11:   data_mux = req_data[3*DATA_W +: DATA_W];
            default: data_mux = '0;
        endcase
    end

    assign out_data = (|gnt) ? data_mux : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state    <= ST_GRANT;
                        gnt      <= onehot4(pick_idx);
                        sel      <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        ptr      <= sel + 2'd1;
                        beat_cnt <= '0;
                        if (pick_any) begin
                            gnt <= onehot4(pick_idx);
                            sel <= pick_idx;
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                        end
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench for mux4_rr_arbiter (DATA_W=8, MAX_BURST=4).
module tb_mux4_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int n_cmp;
    int n_bad;

    logic [7:0] dat [4];
    logic [3:0] gseq [5];
    logic [1:0] iseq [5];

    mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 4'b0000;
        out_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        dat[0] = 8'hA5; dat[1] = 8'h3C; dat[2] = 8'h0F; dat[3] = 8'hF0;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        gseq[0] = 4'b0001; gseq[1] = 4'b0010; gseq[2] = 4'b0100; gseq[3] = 4'b1000; gseq[4] = 4'b0001;
        iseq[0] = 2'd0; iseq[1] = 2'd1; iseq[2] = 2'd2; iseq[3] = 2'd3; iseq[4] = 2'd0;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;

        // 1. async reset mid-burst, then restart from ptr 0
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        req_valid = 4'b0010;
        cycle();
        chk("t1_gnt_pre", 32'(gnt), 32'b0010);
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t1_async_gnt", 32'(gnt), 32'h0);
        chk("t1_async_sel", 32'(sel), 32'h0);
        chk("t1_async_ovalid", 32'(out_valid), 32'h0);
        chk("t1_async_rdy", 32'(req_ready), 32'h0);
        chk("t1_async_ptr", 32'(dut.ptr), 32'h0);
        chk("t1_async_cnt", 32'(dut.beat_cnt), 32'h0);
        rst_n = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("t1_no_comb_gnt", 32'(gnt), 32'h0);
        cycle();
        chk("t1_gnt", 32'(gnt), 32'b0100);
        chk("t1_sel", 32'(sel), 32'd2);

        // 2+6. all requesting: 4-beat bursts rotating, no bubble, data follows sel
        do_reset();
        req_valid = 4'b1111;
        cycle();
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                chk($sformatf("t2_gnt_g%0d_b%0d", g, b), 32'(gnt), 32'(gseq[g]));
                chk($sformatf("t2_sel_g%0d_b%0d", g, b), 32'(sel), 32'(iseq[g]));
                chk($sformatf("t2_ov_g%0d_b%0d", g, b), 32'(out_valid), 32'h1);
                chk($sformatf("t2_data_g%0d_b%0d", g, b), 32'(out_data), 32'(dat[iseq[g]]));
                chk($sformatf("t2_cnt_g%0d_b%0d", g, b), 32'(dut.beat_cnt), 32'(b));
                cycle();
            end
        end
        req_valid = 4'b0000;
        cycle();
        chk("t6_idle_gnt", 32'(gnt), 32'h0);
        chk("t6_idle_data", 32'(out_data), 32'h00);
        chk("t6_idle_ov", 32'(out_valid), 32'h0);

        // 3. single requester 2: back-to-back bursts, ptr=3 after each release
        do_reset();
        req_valid = 4'b0100;
        cycle();
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < 4; b++) begin
                chk($sformatf("t3_gnt_k%0d_b%0d", k, b), 32'(gnt), 32'b0100);
                chk($sformatf("t3_cnt_k%0d_b%0d", k, b), 32'(dut.beat_cnt), 32'(b));
                cycle();
            end
            chk($sformatf("t3_ptr_k%0d", k), 32'(dut.ptr), 32'd3);
        end

        // 4. owner 1 drops valid after 2 beats, req 3 pending
        do_reset();
        req_valid = 4'b1010;
        cycle();
        chk("t4_gnt1", 32'(gnt), 32'b0010);
        cycle();
        cycle();
        chk("t4_cnt2", 32'(dut.beat_cnt), 32'd2);
        req_valid = 4'b1000;
        #1;
        chk("t4_drop_ov", 32'(out_valid), 32'h0);
        cycle();
        chk("t4_gnt3", 32'(gnt), 32'b1000);
        chk("t4_sel3", 32'(sel), 32'd3);
        chk("t4_cnt0", 32'(dut.beat_cnt), 32'd0);
        chk("t4_ptr", 32'(dut.ptr), 32'd2);
        chk("t4_data", 32'(out_data), 32'hF0);

        // 5. back-pressure mid-burst freezes beat_cnt
        do_reset();
        req_valid = 4'b0001;
        cycle();
        cycle();
        chk("t5_cnt1", 32'(dut.beat_cnt), 32'd1);
        out_ready = 1'b0;
        #1;
        chk("t5_rdy_low", 32'(req_ready), 32'b0000);
        for (int s = 0; s < 5; s++) begin
            cycle();
            chk($sformatf("t5_stall_cnt%0d", s), 32'(dut.beat_cnt), 32'd1);
            chk($sformatf("t5_stall_gnt%0d", s), 32'(gnt), 32'b0001);
        end
        out_ready = 1'b1;
        #1;
        chk("t5_rdy_high", 32'(req_ready), 32'b0001);
        cycle();
        chk("t5_cnt2", 32'(dut.beat_cnt), 32'd2);
        cycle();
        chk("t5_cnt3", 32'(dut.beat_cnt), 32'd3);
        cycle();
        chk("t5_regrant_gnt", 32'(gnt), 32'b0001);
        chk("t5_regrant_cnt", 32'(dut.beat_cnt), 32'd0);
        chk("t5_regrant_ptr", 32'(dut.ptr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
